draw_sequencer: RTL and testbench

Top-level job controller for the Lab 2 drawing path. On one start/done handshake it optionally runs the fill-screen engine to clear the 160x120 frame, then runs the Reuleaux-triangle engine. It owns the single VGA pixel port: it muxes, clips and counts the active engine's pixels and presents latched shape parameters to the shape engine.

---
 rtl/draw_pkg.sv | 37 +++
 rtl/pixel_mux_clip.sv | 79 +++++++
 rtl/draw_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : draw_pkg
//  Description : Shared types and constants for the drawing job controller:
//                sequencer state encoding, pixel-bus select, screen size
//                defaults and colour constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

    // Job sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_CLEAR_REL = 3'd2,
        ST_SHAPE     = 3'd3,
        ST_SHAPE_REL = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Which engine currently owns the VGA pixel port.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CLR  = 2'd1,
        SEL_SHP  = 2'd2
    } pix_sel_t;

    // Default visible frame size.
    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;

    // Colour constants.
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

endpackage : draw_pkg
`default_nettype wire

// File: rtl/pixel_mux_clip.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_mux_clip
//  Description : Combinational pixel-bus select and screen clipping. Picks the
//                fill or shape engine bus, or the held values when no engine
//                owns the port, and suppresses the plot strobe for any pixel
//                outside the visible frame.
//  Ports       : sel                      - bus owner (none / fill / shape)
//                clr_*                    - fill engine pixel bus
//                shp_*                    - shape engine pixel bus
//                hold_*                   - last selected pixel values
//                pix_x/pix_y/pix_colour   - selected pixel (y full 8 bits)
//                pix_plot                 - clipped plot strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_mux_clip
    import draw_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
    input  pix_sel_t   sel,
    input  logic [7:0] clr_x,
    input  logic [6:0] clr_y,
    input  logic [2:0] clr_colour,
    input  logic       clr_plot,
    input  logic [7:0] shp_x,
    input  logic [7:0] shp_y,
    input  logic [2:0] shp_vga_colour,
    input  logic       shp_plot,
    input  logic [7:0] hold_x,
    input  logic [7:0] hold_y,
    input  logic [2:0] hold_colour,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic [2:0] pix_colour,
    output logic       pix_plot
);

    // One extra bit so a bound of 256 still compares correctly.
    localparam logic [8:0] c_screen_w = 9'(SCREEN_W);
    localparam logic [8:0] c_screen_h = 9'(SCREEN_H);

    logic w_plot_raw;
    logic w_in_x;
    logic w_in_y;

    always_comb begin
        pix_x      = hold_x;
        pix_y      = hold_y;
        pix_colour = hold_colour;
        w_plot_raw = 1'b0;
        case (sel)
            SEL_CLR: begin
                pix_x      = clr_x;
                pix_y      = {1'b0, clr_y};
                pix_colour = clr_colour;
                w_plot_raw = clr_plot;
            end
            SEL_SHP: begin
                pix_x      = shp_x;
                pix_y      = shp_y;
                pix_colour = shp_vga_colour;
                w_plot_raw = shp_plot;
            end
            default: begin
                w_plot_raw = 1'b0;
            end
        endcase
    end

    // Bounds use the full 8-bit coordinates, so an off-screen y such as 130
    // is dropped rather than wrapping into the 7-bit VGA row address.
    assign w_in_x   = ({1'b0, pix_x} < c_screen_w);
    assign w_in_y   = ({1'b0, pix_y} < c_screen_h);
    assign pix_plot = w_plot_raw & w_in_x & w_in_y;

endmodule : pixel_mux_clip
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : draw_sequencer
//  Description : Drawing job controller. On a start/done handshake it
//                optionally runs the fill engine to clear the frame, then the
//                shape engine. Owns the VGA pixel port (mux + clip), counts
//                plotted pixels and presents latched shape parameters.
//  Ports       : clk, rst_n                 - clock, sync active-low reset
//                start, done                - job handshake (level start)
//                clear_en, colour, centre_x,
//                centre_y, diameter         - job parameters, sampled on start
//                start_clear, clear_colour,
//                done_clear, clr_*          - fill engine interface
//                start_shape, shp_colour,
//                shp_cx, shp_cy, shp_diam,
//                done_shape, shp_*          - shape engine interface
//                vga_x/y/colour/plot        - VGA pixel write port
//                pix_count                  - pixels plotted, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
    parameter logic [2:0]  CLEAR_COLOUR = BLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear_en,
    input  logic [2:0]  colour,
    input  logic [7:0]  centre_x,
    input  logic [7:0]  centre_y,
    input  logic [7:0]  diameter,
    output logic        done,
    output logic        start_clear,
    output logic [2:0]  clear_colour,
    input  logic        done_clear,
    input  logic [7:0]  clr_x,
    input  logic [6:0]  clr_y,
    input  logic [2:0]  clr_colour,
    input  logic        clr_plot,
    output logic        start_shape,
    output logic [2:0]  shp_colour,
    output logic [7:0]  shp_cx,
    output logic [7:0]  shp_cy,
    output logic [7:0]  shp_diam,
    input  logic        done_shape,
    input  logic [7:0]  shp_x,
    input  logic [7:0]  shp_y,
    input  logic [2:0]  shp_vga_colour,
    input  logic        shp_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [14:0] pix_count
);

    localparam logic [14:0] c_pix_max = 15'h7FFF;

    state_t     r_state;
    state_t     w_next;
    pix_sel_t   w_sel;

    logic       r_start_clear;
    logic       r_start_shape;
    logic       r_done;
    logic [2:0] r_colour;
    logic [7:0] r_cx;
    logic [7:0] r_cy;
    logic [7:0] r_diam;
    logic [14:0] r_pix_count;

    logic [7:0] r_hold_x;
    logic [7:0] r_hold_y;
    logic [2:0] r_hold_colour;

    logic [7:0] w_pix_x;
    logic [7:0] w_pix_y;
    logic [2:0] w_pix_colour;
    logic       w_pix_plot;

    logic       w_job_start;

    // ------------------------------------------------------------------
    // State register and registered engine handshakes. The handshake
    // flops are loaded from the next state so they line up exactly with
    // the state they represent and drop together with reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_start_clear <= 1'b0;
            r_start_shape <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_start_clear <= (w_next == ST_CLEAR);
            r_start_shape <= (w_next == ST_SHAPE);
            r_done        <= (w_next == ST_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. start only matters in IDLE and DONE; once a job
    // is running it completes regardless of start.
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_job_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_job_start = 1'b1;
                    w_next      = clear_en ? ST_CLEAR : ST_SHAPE;
                end
            end
            ST_CLEAR: begin
                if (done_clear) begin
                    w_next = ST_CLEAR_REL;
                end
            end
            ST_CLEAR_REL: begin
                // Wait for the fill engine to drop done before handing the
                // port to the shape engine.
                if (!done_clear) begin
                    w_next = ST_SHAPE;
                end
            end
            ST_SHAPE: begin
                if (done_shape) begin
                    w_next = ST_SHAPE_REL;
                end
            end
            ST_SHAPE_REL: begin
                if (!done_shape) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Parameter latch and pixel counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_colour    <= 3'd0;
            r_cx        <= 8'd0;
            r_cy        <= 8'd0;
            r_diam      <= 8'd0;
            r_pix_count <= 15'd0;
        end else if (w_job_start) begin
            r_colour    <= colour;
            r_cx        <= centre_x;
            r_cy        <= centre_y;
            r_diam      <= diameter;
            r_pix_count <= 15'd0;
        end else if (w_pix_plot && (r_pix_count != c_pix_max)) begin
            r_pix_count <= r_pix_count + 15'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pixel port ownership. CLEAR_REL and SHAPE_REL deliberately select
    // nothing so a late strobe from a finishing engine cannot leak out.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = SEL_NONE;
        case (r_state)
            ST_CLEAR: w_sel = SEL_CLR;
            ST_SHAPE: w_sel = SEL_SHP;
            default:  w_sel = SEL_NONE;
        endcase
    end

    // Remember the last selected bus so the VGA coordinates stay stable
    // while no engine owns the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_x      <= 8'd0;
            r_hold_y      <= 8'd0;
            r_hold_colour <= 3'd0;
        end else if (w_sel != SEL_NONE) begin
            r_hold_x      <= w_pix_x;
            r_hold_y      <= w_pix_y;
            r_hold_colour <= w_pix_colour;
        end
    end

    pixel_mux_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_pixel_mux_clip (
        .sel            (w_sel),
        .clr_x          (clr_x),
        .clr_y          (clr_y),
        .clr_colour     (clr_colour),
        .clr_plot       (clr_plot),
        .shp_x          (shp_x),
        .shp_y          (shp_y),
        .shp_vga_colour (shp_vga_colour),
        .shp_plot       (shp_plot),
        .hold_x         (r_hold_x),
        .hold_y         (r_hold_y),
        .hold_colour    (r_hold_colour),
        .pix_x          (w_pix_x),
        .pix_y          (w_pix_y),
        .pix_colour     (w_pix_colour),
        .pix_plot       (w_pix_plot)
    );

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign done         = r_done;
    assign start_clear  = r_start_clear;
    assign start_shape  = r_start_shape;
    assign clear_colour = CLEAR_COLOUR;
    assign shp_colour   = r_colour;
    assign shp_cx       = r_cx;
    assign shp_cy       = r_cy;
    assign shp_diam     = r_diam;
    assign vga_x        = w_pix_x;
    assign vga_y        = w_pix_y[6:0];
    assign vga_colour   = w_pix_colour;
    assign vga_plot     = w_pix_plot;
    assign pix_count    = r_pix_count;

endmodule : draw_sequencer
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_sequencer
//  Description : Directed self-checking bench for draw_sequencer. The bench
//                plays the fill and shape engines from scripted stimulus and
//                compares DUT outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear_en;
    logic [2:0]  colour;
    logic [7:0]  centre_x;
    logic [7:0]  centre_y;
    logic [7:0]  diameter;
    logic        done;
    logic        start_clear;
    logic [2:0]  clear_colour;
    logic        done_clear;
    logic [7:0]  clr_x;
    logic [6:0]  clr_y;
    logic [2:0]  clr_colour;
    logic        clr_plot;
    logic        start_shape;
    logic [2:0]  shp_colour;
    logic [7:0]  shp_cx;
    logic [7:0]  shp_cy;
    logic [7:0]  shp_diam;
    logic        done_shape;
    logic [7:0]  shp_x;
    logic [7:0]  shp_y;
    logic [2:0]  shp_vga_colour;
    logic        shp_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [14:0] pix_count;

    int n_total;
    int n_bad;
    int n_overlap;

    draw_sequencer u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .clear_en       (clear_en),
        .colour         (colour),
        .centre_x       (centre_x),
        .centre_y       (centre_y),
        .diameter       (diameter),
        .done           (done),
        .start_clear    (start_clear),
        .clear_colour   (clear_colour),
        .done_clear     (done_clear),
        .clr_x          (clr_x),
        .clr_y          (clr_y),
        .clr_colour     (clr_colour),
        .clr_plot       (clr_plot),
        .start_shape    (start_shape),
        .shp_colour     (shp_colour),
        .shp_cx         (shp_cx),
        .shp_cy         (shp_cy),
        .shp_diam       (shp_diam),
        .done_shape     (done_shape),
        .shp_x          (shp_x),
        .shp_y          (shp_y),
        .shp_vga_colour (shp_vga_colour),
        .shp_plot       (shp_plot),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot),
        .pix_count      (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine starts must never be high together.
    always @(negedge clk) begin
        if (start_clear && start_shape) n_overlap = n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change at the falling edge; the DUT samples them at the next
    // rising edge and results are observed at the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_job(input logic ce, input logic [2:0] col, input logic [7:0] cx,
                           input logic [7:0] cy, input logic [7:0] d);
        start    = 1'b1;
        clear_en = ce;
        colour   = col;
        centre_x = cx;
        centre_y = cy;
        diameter = d;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        n_overlap = 0;
        rst_n = 1'b0; start = 1'b0; clear_en = 1'b0; colour = 3'd0;
        centre_x = 8'd0; centre_y = 8'd0; diameter = 8'd0;
        done_clear = 1'b0; clr_x = 8'd0; clr_y = 7'd0; clr_colour = 3'd0; clr_plot = 1'b0;
        done_shape = 1'b0; shp_x = 8'd0; shp_y = 8'd0; shp_vga_colour = 3'd0; shp_plot = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_done", done, 0);
        check("rst_start_clear", start_clear, 0);
        check("rst_start_shape", start_shape, 0);
        check("rst_vga_plot", vga_plot, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_shp_cx", shp_cx, 0);
        check("clear_colour", clear_colour, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- job without clear; clipping ----------------
        set_job(1'b0, 3'b010, 8'd80, 8'd60, 8'd80);
        settle();
        check("a_shape_before", start_shape, 0);
        tick();
        check("a_start_shape", start_shape, 1);
        check("a_start_clear", start_clear, 0);
        check("a_shp_cx", shp_cx, 80);
        check("a_shp_cy", shp_cy, 60);
        check("a_shp_diam", shp_diam, 80);
        check("a_shp_colour", shp_colour, 3'b010);
        // Dropping start and moving centre_x mid-job must have no effect.
        start = 1'b0; centre_x = 8'd20;
        shp_vga_colour = 3'b010;
        shp_x = 8'd170; shp_y = 8'd10;  shp_plot = 1'b1; settle();
        check("clip_x170", vga_plot, 0);
        tick();
        shp_x = 8'd5;   shp_y = 8'd125; settle();
        check("clip_y125", vga_plot, 0);
        tick();
        shp_x = 8'd5;   shp_y = 8'd130; settle();
        check("clip_y130", vga_plot, 0);
        tick();
        shp_x = 8'd159; shp_y = 8'd119; settle();
        check("clip_edge_plot", vga_plot, 1);
        check("clip_edge_x", vga_x, 159);
        check("clip_edge_y", vga_y, 119);
        check("clip_edge_colour", vga_colour, 3'b010);
        tick();
        shp_plot = 1'b0; shp_x = 8'd33; done_shape = 1'b1; settle();
        check("a_pix_count", pix_count, 1);
        check("a_shp_cx_held", shp_cx, 80);
        check("a_still_shape", start_shape, 1);
        tick();
        shp_x = 8'd44; shp_plot = 1'b1; settle();
        check("a_rel_start_shape", start_shape, 0);
        check("a_rel_plot", vga_plot, 0);
        check("a_rel_hold_x", vga_x, 33);
        shp_plot = 1'b0; done_shape = 1'b0;
        tick();
        check("a_done", done, 1);
        tick();
        check("a_back_idle_done", done, 0);
        check("a_last_count", pix_count, 1);

        // ---------------- full job with clear ----------------
        set_job(1'b1, 3'b010, 8'd80, 8'd60, 8'd80);
        tick();
        check("b_start_clear", start_clear, 1);
        check("b_no_shape", start_shape, 0);
        check("b_count_cleared", pix_count, 0);
        clr_colour = 3'b000;
        for (int i = 0; i < 19200; i++) begin
            clr_x    = 8'(i % 160);
            clr_y    = 7'(i / 160);
            clr_plot = 1'b1;
            tick();
        end
        clr_plot = 1'b0; done_clear = 1'b1;
        tick();
        check("b_clear_rel_sc", start_clear, 0);
        check("b_clear_rel_ss", start_shape, 0);
        check("b_fill_count", pix_count, 19200);
        done_clear = 1'b0;
        tick();
        check("b_start_shape", start_shape, 1);
        shp_vga_colour = 3'b010;
        for (int i = 0; i < 500; i++) begin
            shp_x    = 8'(40 + (i % 80));
            shp_y    = 8'(20 + (i / 80));
            shp_plot = 1'b1;
            tick();
        end
        shp_plot = 1'b0; done_shape = 1'b1;
        tick();
        done_shape = 1'b0;
        tick();
        check("b_done", done, 1);
        check("b_total_count", pix_count, 19700);
        // start still high: stays in DONE, no second job.
        tick(); tick(); tick();
        check("b_done_held", done, 1);
        check("b_no_rerun", start_shape, 0);
        check("b_count_kept", pix_count, 19700);
        start = 1'b0; centre_x = 8'd40;
        tick();
        check("b_idle", done, 0);
        set_job(1'b0, 3'b010, 8'd40, 8'd60, 8'd80);
        tick();
        check("b2_start_shape", start_shape, 1);
        check("b2_shp_cx", shp_cx, 40);
        check("b2_count_cleared", pix_count, 0);
        start = 1'b0; done_shape = 1'b1;
        tick();
        done_shape = 1'b0;
        tick();
        check("b2_done", done, 1);
        tick();

        // ---------------- done_clear held with late plots ----------------
        set_job(1'b1, 3'b111, 8'd10, 8'd10, 8'd8);
        tick();
        check("c_start_clear", start_clear, 1);
        clr_x = 8'd1; clr_y = 7'd1; clr_plot = 1'b1; done_clear = 1'b1; settle();
        check("c_plot_with_done", vga_plot, 1);
        tick();
        settle();
        check("c_rel1_plot", vga_plot, 0);
        check("c_rel1_sc", start_clear, 0);
        check("c_rel1_ss", start_shape, 0);
        tick();
        settle();
        check("c_rel2_plot", vga_plot, 0);
        check("c_rel2_ss", start_shape, 0);
        done_clear = 1'b0; clr_plot = 1'b0;
        tick();
        check("c_start_shape", start_shape, 1);
        check("c_count", pix_count, 1);

        // ---------------- reset during SHAPE ----------------
        rst_n = 1'b0;
        tick();
        check("d_rst_ss", start_shape, 0);
        check("d_rst_done", done, 0);
        check("d_rst_count", pix_count, 0);
        check("d_rst_cx", shp_cx, 0);
        rst_n = 1'b1; start = 1'b0;
        tick(); tick();
        check("d_idle_ss", start_shape, 0);
        check("d_idle_sc", start_clear, 0);

        check("no_overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_draw_sequencer
`default_nettype wire
